// File: rtl/run_monitor_if.sv
// Bus between the multicycle datapath and run_monitor: fetch observation inputs,
// trace readout port, run status and a debug view of the monitor FSM.
interface run_monitor_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // FetchEn is a valid strobe with no ready: in RUN every strobed fetch is accepted on that edge.
  // RdReq is a pop request answered one edge later by a one-cycle RdValid; an empty pop yields no RdValid.
  logic [WIDTH-1:0]   PCIn;
  logic [WIDTH-1:0]   IRIn;
  logic               FetchEn;
  logic               RdReq;
  logic               Halted;
  logic [1:0]         HaltCause;
  logic [31:0]        CycleCount;
  logic [31:0]        InstrCount;
  logic [2*WIDTH-1:0] RdData;
  logic               RdValid;
  logic               Empty;
  logic [CW-1:0]      Count;
  logic               state_dbg;

  modport master (
    output PCIn, IRIn, FetchEn, RdReq,
    input  Halted, HaltCause, CycleCount, InstrCount, RdData, RdValid, Empty, Count, state_dbg
  );

  modport slave (
    input  PCIn, IRIn, FetchEn, RdReq,
    output Halted, HaltCause, CycleCount, InstrCount, RdData, RdValid, Empty, Count, state_dbg
  );
endinterface

// File: rtl/run_monitor.sv
// Run monitor: counts cycles/fetches, halts on illegal opcode, self-loop or timeout.
// Define RUN_MONITOR_TRACE_EN to build the circular fetch trace and its readout port.
module run_monitor #(
  parameter int                    WIDTH        = 16,
  parameter int                    OPW          = 4,
  parameter logic [(1<<OPW)-1:0]   ILLEGAL_MASK = '0,
  parameter int                    DEPTH        = 16,
  parameter int                    MAX_CYCLES   = 65535
) (
  input logic        CLK,
  input logic        CLR,
  run_monitor_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic [OPW-1:0]    opcode;
  logic              fire_illegal;
  logic              fire_loop;
  logic              fire_timeout;
  logic              halt_now;
  logic [1:0]        cause_next;
  logic [WIDTH-1:0]  prev_pc;
  logic              prev_valid;
  logic [31:0]       cycle_count;
  logic [31:0]       instr_count;
  logic [1:0]        halt_cause;

  assign opcode = bus.IRIn[WIDTH-1 -: OPW];

  // Halt sources are judged on the same edge that accepts the fetch.
  always_comb begin
    fire_illegal = bus.FetchEn && ILLEGAL_MASK[opcode];
    fire_loop    = bus.FetchEn && prev_valid && (bus.PCIn == prev_pc);
    fire_timeout = (MAX_CYCLES != 0) && (cycle_count == 32'(MAX_CYCLES - 1));
    halt_now     = (state == RUN) && (fire_illegal || fire_loop || fire_timeout);
    if (fire_illegal)      cause_next = 2'b01;
    else if (fire_loop)    cause_next = 2'b10;
    else if (fire_timeout) cause_next = 2'b11;
    else                   cause_next = 2'b00;
  end

  always_ff @(posedge CLK) begin
    if (CLR) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (halt_now) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    bus.Halted    = (state == HALT);
    bus.state_dbg = state;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      cycle_count <= '0;
      instr_count <= '0;
      prev_pc     <= '0;
      prev_valid  <= 1'b0;
      halt_cause  <= 2'b00;
    end else if (state == RUN) begin
      cycle_count <= cycle_count + 32'd1;
      if (bus.FetchEn) begin
        instr_count <= instr_count + 32'd1;
        prev_pc     <= bus.PCIn;
        prev_valid  <= 1'b1;
      end
      if (halt_now) halt_cause <= cause_next;
    end
  end

  assign bus.HaltCause  = halt_cause;
  assign bus.CycleCount = cycle_count;
  assign bus.InstrCount = instr_count;

`ifdef RUN_MONITOR_TRACE_EN
  localparam int AW = $clog2(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               push;
  logic               pop;

  assign push = (state == RUN) && bus.FetchEn;
  assign pop  = (state == HALT) && bus.RdReq && (count != '0);

  // Pointers are AW bits wide, so wrap modulo DEPTH is free; a full buffer drops its oldest entry.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (push) begin
        mem[wr_ptr] <= {bus.PCIn, bus.IRIn};
        wr_ptr      <= wr_ptr + 1'b1;
        if (count == CW'(DEPTH)) rd_ptr <= rd_ptr + 1'b1;
        else                     count  <= count + 1'b1;
      end else if (pop) begin
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        count    <= count - 1'b1;
        rd_valid <= 1'b1;
      end
    end
  end

  assign bus.RdData  = rd_data;
  assign bus.RdValid = rd_valid;
  assign bus.Count   = count;
  assign bus.Empty   = (count == '0);
`else
  logic unused_ok;

  assign unused_ok   = &{1'b0, bus.RdReq, bus.IRIn};
  assign bus.RdData  = '0;
  assign bus.RdValid = 1'b0;
  assign bus.Count   = CW'(0);
  assign bus.Empty   = 1'b1;
`endif
endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: instance A (DEPTH 16) covers fetch/halt/readout,
// instance B (DEPTH 4, MAX_CYCLES 50) covers timeout and trace wrap.
module tb_run_monitor;
`ifdef RUN_MONITOR_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_a;
  logic        clr_b;
  int          assert_cnt = 0;
  int          fail_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  run_monitor_if #(.WIDTH(16), .DEPTH(16)) a_if();
  run_monitor_if #(.WIDTH(16), .DEPTH(4))  b_if();

  run_monitor #(.WIDTH(16), .OPW(4), .ILLEGAL_MASK(16'h8000), .DEPTH(16), .MAX_CYCLES(1000))
    u_a (.CLK(clk), .CLR(clr_a), .bus(a_if));
  run_monitor #(.WIDTH(16), .OPW(4), .ILLEGAL_MASK(16'h8000), .DEPTH(4), .MAX_CYCLES(50))
    u_b (.CLK(clk), .CLR(clr_b), .bus(b_if));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a;
    a_if.FetchEn = 1'b0; a_if.RdReq = 1'b0; clr_a = 1'b1;
    tick; tick;
    clr_a = 1'b0;
  endtask

  task automatic fetch_a(input logic [15:0] pc, input logic [15:0] ir);
    a_if.FetchEn = 1'b1; a_if.PCIn = pc; a_if.IRIn = ir;
    tick;
    a_if.FetchEn = 1'b0;
  endtask

  task automatic pop_a;
    a_if.RdReq = 1'b1;
    tick;
    a_if.RdReq = 1'b0;
  endtask

  task automatic fetch_b(input logic [15:0] pc, input logic [15:0] ir);
    b_if.FetchEn = 1'b1; b_if.PCIn = pc; b_if.IRIn = ir;
    tick;
    b_if.FetchEn = 1'b0;
  endtask

  task automatic test_reset;
    a_if.PCIn = '0; a_if.IRIn = '0; b_if.PCIn = '0; b_if.IRIn = '0;
    b_if.FetchEn = 1'b0; b_if.RdReq = 1'b0; clr_b = 1'b1;
    clear_a;
    clr_b = 1'b0;
    assert_cnt++; if (a_if.Halted !== 1'b0) begin fail_cnt++; $display("FAIL reset_halted: got %0d want 0", a_if.Halted); end
    assert_cnt++; if (a_if.HaltCause !== 2'b00) begin fail_cnt++; $display("FAIL reset_cause: got %0d want 0", a_if.HaltCause); end
    assert_cnt++; if (a_if.CycleCount !== 32'd0) begin fail_cnt++; $display("FAIL reset_cycles: got %0d want 0", a_if.CycleCount); end
    assert_cnt++; if (a_if.InstrCount !== 32'd0) begin fail_cnt++; $display("FAIL reset_instrs: got %0d want 0", a_if.InstrCount); end
    assert_cnt++; if (a_if.RdData !== 32'd0) begin fail_cnt++; $display("FAIL reset_rddata: got %h want 0", a_if.RdData); end
    assert_cnt++; if (a_if.RdValid !== 1'b0) begin fail_cnt++; $display("FAIL reset_rdvalid: got %0d want 0", a_if.RdValid); end
    assert_cnt++; if (a_if.Empty !== 1'b1) begin fail_cnt++; $display("FAIL reset_empty: got %0d want 1", a_if.Empty); end
    assert_cnt++; if (a_if.Count !== 5'd0) begin fail_cnt++; $display("FAIL reset_count: got %0d want 0", a_if.Count); end
    assert_cnt++; if (a_if.state_dbg !== 1'b0) begin fail_cnt++; $display("FAIL reset_state: got %0d want 0", a_if.state_dbg); end
  endtask

  // Five fetches, one every 4th cycle: 20 cycles since CLR fell.
  task automatic test_run_fetch;
    for (int i = 0; i < 5; i++) begin
      fetch_a(16'(i), 16'h1000 + 16'(i));
      repeat (3) tick;
    end
    assert_cnt++; if (a_if.InstrCount !== 32'd5) begin fail_cnt++; $display("FAIL run_instrs: got %0d want 5", a_if.InstrCount); end
    assert_cnt++; if (a_if.CycleCount !== 32'd20) begin fail_cnt++; $display("FAIL run_cycles: got %0d want 20", a_if.CycleCount); end
    assert_cnt++; if (a_if.Count !== (TR ? 5'd5 : 5'd0)) begin fail_cnt++; $display("FAIL run_count: got %0d want %0d", a_if.Count, TR ? 5 : 0); end
    assert_cnt++; if (a_if.Empty !== !TR) begin fail_cnt++; $display("FAIL run_empty: got %0d want %0d", a_if.Empty, !TR); end
    assert_cnt++; if (a_if.Halted !== 1'b0) begin fail_cnt++; $display("FAIL run_halted: got %0d want 0", a_if.Halted); end
  endtask

  task automatic test_illegal;
    logic [31:0] exp;
    fetch_a(16'h0007, 16'hF000);
    assert_cnt++; if (a_if.Halted !== 1'b1) begin fail_cnt++; $display("FAIL ill_halted: got %0d want 1", a_if.Halted); end
    assert_cnt++; if (a_if.HaltCause !== 2'b01) begin fail_cnt++; $display("FAIL ill_cause: got %0d want 1", a_if.HaltCause); end
    assert_cnt++; if (a_if.InstrCount !== 32'd6) begin fail_cnt++; $display("FAIL ill_instrs: got %0d want 6", a_if.InstrCount); end
    assert_cnt++; if (a_if.CycleCount !== 32'd21) begin fail_cnt++; $display("FAIL ill_cycles: got %0d want 21", a_if.CycleCount); end
    fetch_a(16'h0008, 16'h1008);
    tick;
    assert_cnt++; if (a_if.InstrCount !== 32'd6) begin fail_cnt++; $display("FAIL ill_frozen_instrs: got %0d want 6", a_if.InstrCount); end
    assert_cnt++; if (a_if.CycleCount !== 32'd21) begin fail_cnt++; $display("FAIL ill_frozen_cycles: got %0d want 21", a_if.CycleCount); end
    assert_cnt++; if (a_if.Count !== (TR ? 5'd6 : 5'd0)) begin fail_cnt++; $display("FAIL ill_count: got %0d want %0d", a_if.Count, TR ? 6 : 0); end
    if (TR) begin
      exp_q = {32'h0000_1000, 32'h0001_1001, 32'h0002_1002, 32'h0003_1003, 32'h0004_1004, 32'h0007_F000};
    end
    for (int k = 0; k < 6; k++) begin
      pop_a;
      exp = '0;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      assert_cnt++; if (a_if.RdValid !== TR) begin fail_cnt++; $display("FAIL ill_rdvalid[%0d]: got %0d want %0d", k, a_if.RdValid, TR); end
      assert_cnt++; if (a_if.RdData !== exp) begin fail_cnt++; $display("FAIL ill_rddata[%0d]: got %h want %h", k, a_if.RdData, exp); end
    end
    assert_cnt++; if (a_if.Empty !== 1'b1) begin fail_cnt++; $display("FAIL ill_drained_empty: got %0d want 1", a_if.Empty); end
    pop_a;
    assert_cnt++; if (a_if.RdValid !== 1'b0) begin fail_cnt++; $display("FAIL ill_empty_pop_valid: got %0d want 0", a_if.RdValid); end
    assert_cnt++; if (a_if.RdData !== (TR ? 32'h0007_F000 : 32'h0)) begin fail_cnt++; $display("FAIL ill_empty_pop_hold: got %h want %h", a_if.RdData, TR ? 32'h0007_F000 : 32'h0); end
  endtask

  task automatic test_self_loop;
    clear_a;
    fetch_a(16'd10, 16'h2000);
    assert_cnt++; if (a_if.Halted !== 1'b0) begin fail_cnt++; $display("FAIL loop_first_halted: got %0d want 0", a_if.Halted); end
    fetch_a(16'd10, 16'h2001);
    assert_cnt++; if (a_if.Halted !== 1'b1) begin fail_cnt++; $display("FAIL loop_halted: got %0d want 1", a_if.Halted); end
    assert_cnt++; if (a_if.HaltCause !== 2'b10) begin fail_cnt++; $display("FAIL loop_cause: got %0d want 2", a_if.HaltCause); end
    assert_cnt++; if (a_if.InstrCount !== 32'd2) begin fail_cnt++; $display("FAIL loop_instrs: got %0d want 2", a_if.InstrCount); end
    assert_cnt++; if (a_if.CycleCount !== 32'd2) begin fail_cnt++; $display("FAIL loop_cycles: got %0d want 2", a_if.CycleCount); end
    assert_cnt++; if (a_if.Count !== (TR ? 5'd2 : 5'd0)) begin fail_cnt++; $display("FAIL loop_count: got %0d want %0d", a_if.Count, TR ? 2 : 0); end
  endtask

  task automatic test_same_edge;
    clear_a;
    fetch_a(16'd3, 16'h1003);
    fetch_a(16'd3, 16'hF003);
    assert_cnt++; if (a_if.Halted !== 1'b1) begin fail_cnt++; $display("FAIL same_halted: got %0d want 1", a_if.Halted); end
    assert_cnt++; if (a_if.HaltCause !== 2'b01) begin fail_cnt++; $display("FAIL same_cause: got %0d want 1", a_if.HaltCause); end
  endtask

  task automatic test_timeout;
    int n;
    logic [31:0] exp;
    clr_b = 1'b1; tick; tick; clr_b = 1'b0;
    for (int i = 0; i < 10; i++) fetch_b(16'(i), 16'h1000 + 16'(i));
    b_if.RdReq = 1'b1; tick; b_if.RdReq = 1'b0;
    assert_cnt++; if (b_if.RdValid !== 1'b0) begin fail_cnt++; $display("FAIL tmo_run_rdreq: got %0d want 0", b_if.RdValid); end
    assert_cnt++; if (b_if.Count !== (TR ? 3'd4 : 3'd0)) begin fail_cnt++; $display("FAIL tmo_sat_count: got %0d want %0d", b_if.Count, TR ? 4 : 0); end
    n = 11;
    while (b_if.Halted !== 1'b1 && n < 100) begin tick; n++; end
    assert_cnt++; if (n !== 50) begin fail_cnt++; $display("FAIL tmo_halt_cycle: got %0d want 50", n); end
    assert_cnt++; if (b_if.HaltCause !== 2'b11) begin fail_cnt++; $display("FAIL tmo_cause: got %0d want 3", b_if.HaltCause); end
    assert_cnt++; if (b_if.CycleCount !== 32'd50) begin fail_cnt++; $display("FAIL tmo_cycles: got %0d want 50", b_if.CycleCount); end
    assert_cnt++; if (b_if.InstrCount !== 32'd10) begin fail_cnt++; $display("FAIL tmo_instrs: got %0d want 10", b_if.InstrCount); end
    tick;
    assert_cnt++; if (b_if.CycleCount !== 32'd50) begin fail_cnt++; $display("FAIL tmo_frozen: got %0d want 50", b_if.CycleCount); end
    if (TR) exp_q = {32'h0006_1006, 32'h0007_1007, 32'h0008_1008, 32'h0009_1009};
    b_if.RdReq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      exp = TR ? 32'h0009_1009 : 32'h0;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      assert_cnt++; if (b_if.RdValid !== (TR && k < 4)) begin fail_cnt++; $display("FAIL tmo_rdvalid[%0d]: got %0d want %0d", k, b_if.RdValid, TR && k < 4); end
      assert_cnt++; if (b_if.RdData !== exp) begin fail_cnt++; $display("FAIL tmo_rddata[%0d]: got %h want %h", k, b_if.RdData, exp); end
    end
    b_if.RdReq = 1'b0;
    assert_cnt++; if (b_if.Empty !== 1'b1) begin fail_cnt++; $display("FAIL tmo_empty: got %0d want 1", b_if.Empty); end
  endtask

  task automatic test_clr_readout;
    clear_a;
    fetch_a(16'd20, 16'h1014);
    fetch_a(16'd21, 16'h1015);
    fetch_a(16'd22, 16'h1016);
    fetch_a(16'd23, 16'hF017);
    pop_a;
    assert_cnt++; if (a_if.RdValid !== TR) begin fail_cnt++; $display("FAIL clr_pop_valid: got %0d want %0d", a_if.RdValid, TR); end
    pop_a;
    assert_cnt++; if (a_if.Count !== (TR ? 5'd2 : 5'd0)) begin fail_cnt++; $display("FAIL clr_pre_count: got %0d want %0d", a_if.Count, TR ? 2 : 0); end
    clr_a = 1'b1; a_if.FetchEn = 1'b1; a_if.PCIn = 16'd30; a_if.IRIn = 16'h101E; a_if.RdReq = 1'b1;
    tick;
    assert_cnt++; if (a_if.Halted !== 1'b0) begin fail_cnt++; $display("FAIL clr_halted: got %0d want 0", a_if.Halted); end
    assert_cnt++; if (a_if.HaltCause !== 2'b00) begin fail_cnt++; $display("FAIL clr_cause: got %0d want 0", a_if.HaltCause); end
    assert_cnt++; if (a_if.state_dbg !== 1'b0) begin fail_cnt++; $display("FAIL clr_state: got %0d want 0", a_if.state_dbg); end
    assert_cnt++; if (a_if.CycleCount !== 32'd0) begin fail_cnt++; $display("FAIL clr_cycles: got %0d want 0", a_if.CycleCount); end
    assert_cnt++; if (a_if.InstrCount !== 32'd0) begin fail_cnt++; $display("FAIL clr_instrs: got %0d want 0", a_if.InstrCount); end
    assert_cnt++; if (a_if.RdData !== 32'd0) begin fail_cnt++; $display("FAIL clr_rddata: got %h want 0", a_if.RdData); end
    assert_cnt++; if (a_if.RdValid !== 1'b0) begin fail_cnt++; $display("FAIL clr_rdvalid: got %0d want 0", a_if.RdValid); end
    assert_cnt++; if (a_if.Count !== 5'd0) begin fail_cnt++; $display("FAIL clr_count: got %0d want 0", a_if.Count); end
    assert_cnt++; if (a_if.Empty !== 1'b1) begin fail_cnt++; $display("FAIL clr_empty: got %0d want 1", a_if.Empty); end
    clr_a = 1'b0; a_if.FetchEn = 1'b0; a_if.RdReq = 1'b0;
    tick;
    assert_cnt++; if (a_if.CycleCount !== 32'd1) begin fail_cnt++; $display("FAIL clr_after_cycles: got %0d want 1", a_if.CycleCount); end
    assert_cnt++; if (a_if.InstrCount !== 32'd0) begin fail_cnt++; $display("FAIL clr_after_instrs: got %0d want 0", a_if.InstrCount); end
  endtask

  initial begin
    test_reset;
    test_run_fetch;
    test_illegal;
    test_self_loop;
    test_same_edge;
    test_timeout;
    test_clr_readout;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
